// File: rtl/lzc_pipe_pkg.sv
// Shared types and sizing helpers for the pipelined leading/trailing zero/one counter.
package lzc_pipe_pkg;

  typedef enum logic [1:0] {
    CLZ = 2'd0,
    CLO = 2'd1,
    CTZ = 2'd2,
    CTO = 2'd3
  } lzc_mode_e;

  // Width of a count able to hold 0..n inclusive (n a power of two).
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  // Number of register stages (pipeline latency) for a tree over wi bits
  // with a register after every re levels, the last level always registered.
  function automatic int n_stages(input int wi, input int re);
    return ($clog2(wi) + re - 1) / re;
  endfunction

endpackage

// File: rtl/lzc_merge.sv
// Combines two W-bit leading-zero half-counts (left = more significant half)
// into one (W+1)-bit count. A set MSB means that half was entirely zero.
module lzc_merge #(
  parameter int W = 2
) (
  input  logic [W-1:0] left_i,
  input  logic [W-1:0] right_i,
  output logic [W:0]   cnt_o
);

  // Left half all-zero extends the run into the right half.
  always_comb begin
    if (!left_i[W-1]) begin
      cnt_o = {1'b0, left_i};
    end else if (!right_i[W-1]) begin
      cnt_o = {2'b01, right_i[W-2:0]};
    end else begin
      cnt_o = {right_i, 1'b0};
    end
  end

endmodule

// File: rtl/lzc_pipe.sv
// Pipelined CLZ/CLO/CTZ/CTO counter with valid/ready flow control.
// Inputs are folded to a CLZ problem, then a binary merge tree is built with
// register stages after every REG_EVERY levels and always after the last one.
module lzc_pipe
  import lzc_pipe_pkg::*;
#(
  parameter int WI_SZ     = 32,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WI_SZ-1:0]          in_data,
  input  logic [1:0]                in_mode,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [cnt_w(WI_SZ)-1:0]   out_count,
  output logic                      out_all,
  output logic [TAG_W-1:0]          out_tag
);

  localparam int LEVELS = $clog2(WI_SZ);
  localparam int CW     = cnt_w(WI_SZ);

  lzc_mode_e        mode_s;
  logic [WI_SZ-1:0] inv_s;
  logic [WI_SZ-1:0] pre_s;

  // Valid/tag seen at the output of level k (index 0 is the raw input).
  logic [LEVELS:0]     v_s;
  logic [TAG_W-1:0]    tag_s [LEVELS+1];
  // rdy_s[k]: level k can take what level k-1 presents; top entry is out_ready.
  logic [LEVELS+1:1]   rdy_s;

  assign mode_s             = lzc_mode_e'(in_mode);
  assign v_s[0]             = in_valid;
  assign tag_s[0]           = in_tag;
  assign rdy_s[LEVELS+1]    = out_ready;
  assign in_ready           = rdy_s[1];

  // Reduce every mode to CLZ: invert for one-counting, reverse for trailing.
  always_comb begin
    inv_s = (mode_s == CLO || mode_s == CTO) ? ~in_data : in_data;
    pre_s = inv_s;
    for (int i = 0; i < WI_SZ; i++) begin
      if (mode_s == CTZ || mode_s == CTO) begin
        pre_s[i] = inv_s[WI_SZ-1-i];
      end else begin
        pre_s[i] = inv_s[i];
      end
    end
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : gen_lvl
    localparam int NN = WI_SZ >> k;   // nodes at this level
    localparam int W  = k + 1;        // count width at this level

    logic [NN*W-1:0] cnt_c;  // combinational counts of this level
    logic [NN*W-1:0] cnt_o;  // counts handed to the next level

    if (k == 1) begin : g_leaf
      // Node n covers bits {2n+1, 2n}: 00->2, 01->1, 1x->0.
      for (genvar n = 0; n < NN; n++) begin : g_node
        assign cnt_c[n*2 +: 2] = {~pre_s[2*n+1] & ~pre_s[2*n],
                                  ~pre_s[2*n+1] &  pre_s[2*n]};
      end
    end else begin : g_merge
      for (genvar n = 0; n < NN; n++) begin : g_node
        lzc_merge #(.W(k)) u_merge (
          .left_i  (gen_lvl[k-1].cnt_o[(2*n+1)*k +: k]),
          .right_i (gen_lvl[k-1].cnt_o[(2*n)*k   +: k]),
          .cnt_o   (cnt_c[n*W +: W])
        );
      end
    end

    if ((k % REG_EVERY) == 0 || k == LEVELS) begin : g_reg
      logic             v_q;
      logic [NN*W-1:0]  cnt_q;
      logic [TAG_W-1:0] tag_q;

      assign rdy_s[k]   = !v_q || rdy_s[k+1];
      assign v_s[k]     = v_q;
      assign cnt_o      = cnt_q;
      assign tag_s[k]   = tag_q;

      // Stage register: loads when it can advance, holds when stalled, flush empties it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q   <= 1'b0;
          cnt_q <= '0;
          tag_q <= '0;
        end else if (flush) begin
          v_q   <= 1'b0;
        end else if (rdy_s[k]) begin
          v_q   <= v_s[k-1];
          cnt_q <= cnt_c;
          tag_q <= tag_s[k-1];
        end
      end
    end else begin : g_thru
      assign rdy_s[k]   = rdy_s[k+1];
      assign v_s[k]     = v_s[k-1];
      assign cnt_o      = cnt_c;
      assign tag_s[k]   = tag_s[k-1];
    end
  end

  // Final level is always registered, so these are register outputs.
  assign out_valid = v_s[LEVELS];
  assign out_count = gen_lvl[LEVELS].cnt_o;
  assign out_all   = out_count[CW-1];
  assign out_tag   = tag_s[LEVELS];

endmodule

// File: tb/tb_lzc_pipe.sv
// Directed self-checking bench for lzc_pipe, plus a small parameter sweep.
module tb_lzc_pipe;
  import lzc_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_all;
  logic [31:0] in_data;
  logic [1:0]  in_mode;
  logic [3:0]  in_tag, out_tag;
  logic [5:0]  out_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lzc_pipe #(.WI_SZ(32), .REG_EVERY(2), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_all(out_all), .out_tag(out_tag)
  );

  // Sweep instances: {2,8,64} x {1,3}, sharing one stimulus bus.
  logic        sw_valid;
  logic [63:0] sw_data;
  logic [1:0]  sw_mode;
  logic [3:0]  sw_tag;
  logic        sw_ov   [6];
  logic        sw_ir   [6];
  logic        sw_all  [6];
  logic [6:0]  sw_cnt  [6];
  logic [3:0]  sw_otag [6];

  for (genvar gi = 0; gi < 6; gi++) begin : g_sw
    localparam int WS  = (gi < 2) ? 2 : ((gi < 4) ? 8 : 64);
    localparam int RE  = ((gi % 2) == 0) ? 1 : 3;
    localparam int CWS = $clog2(WS) + 1;
    logic [CWS-1:0] c;
    logic           ov, ir, al;
    logic [3:0]     t;
    lzc_pipe #(.WI_SZ(WS), .REG_EVERY(RE), .TAG_W(4)) u_sw (
      .clk(clk), .rst_n(rst_n), .flush(1'b0),
      .in_valid(sw_valid), .in_ready(ir), .in_data(sw_data[WS-1:0]),
      .in_mode(sw_mode), .in_tag(sw_tag),
      .out_valid(ov), .out_ready(1'b1), .out_count(c),
      .out_all(al), .out_tag(t)
    );
    assign sw_cnt[gi]  = 7'(c);
    assign sw_ov[gi]   = ov;
    assign sw_ir[gi]   = ir;
    assign sw_all[gi]  = al;
    assign sw_otag[gi] = t;
  end

  // Bit-serial reference: count matching bits from the selected end.
  function automatic int ref_cnt(input logic [63:0] d, input int w, input logic [1:0] m);
    int   c    = 0;
    logic stop = 1'b0;
    int   pos;
    for (int i = 0; i < w; i++) begin
      pos = m[1] ? i : (w - 1 - i);
      if (!stop) begin
        if (d[pos] == m[0]) c++;
        else stop = 1'b1;
      end
    end
    return c;
  endfunction

  // Drive one transaction from a negedge and capture the first result.
  task automatic run_one(input logic [31:0] d, input logic [1:0] m, input logic [3:0] t,
                         output logic [5:0] c, output logic a, output logic [3:0] tg,
                         output int lat);
    lat = -1; c = 6'd0; a = 1'b0; tg = 4'd0;
    in_valid = 1'b1; in_data = d; in_mode = m; in_tag = t;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid && lat < 0) begin
        lat = i; c = out_count; a = out_all; tg = out_tag;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
    n_cmp++; if (out_count !== 6'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", out_count); end
    n_cmp++; if (out_all !== 1'b0) begin n_err++; $display("FAIL reset_all: got %0b expected 0", out_all); end
    n_cmp++; if (out_tag !== 4'd0) begin n_err++; $display("FAIL reset_tag: got %0d expected 0", out_tag); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
  endtask

  task automatic test_latency();
    logic [5:0] c; logic a; logic [3:0] tg; int lat;
    run_one(32'h0001_0000, CLZ, 4'd1, c, a, tg, lat);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL lat_clz: got %0d expected 3", lat); end
    n_cmp++; if (c !== 6'd15) begin n_err++; $display("FAIL cnt_clz_bit16: got %0d expected 15", c); end
    n_cmp++; if (a !== 1'b0) begin n_err++; $display("FAIL all_clz_bit16: got %0b expected 0", a); end
    n_cmp++; if (tg !== 4'd1) begin n_err++; $display("FAIL tag_clz_bit16: got %0d expected 1", tg); end
    run_one(32'h0000_0000, CLZ, 4'd2, c, a, tg, lat);
    n_cmp++; if (c !== 6'd32) begin n_err++; $display("FAIL cnt_clz_zero: got %0d expected 32", c); end
    n_cmp++; if (a !== 1'b1) begin n_err++; $display("FAIL all_clz_zero: got %0b expected 1", a); end
    run_one(32'hFFFF_FFFF, CLO, 4'd3, c, a, tg, lat);
    n_cmp++; if (c !== 6'd32) begin n_err++; $display("FAIL cnt_clo_ones: got %0d expected 32", c); end
    run_one(32'h0000_0001, CTZ, 4'd4, c, a, tg, lat);
    n_cmp++; if (c !== 6'd0) begin n_err++; $display("FAIL cnt_ctz_bit0: got %0d expected 0", c); end
  endtask

  task automatic test_modes();
    logic [31:0] d [4] = '{32'hFFF0_000F, 32'hFFF0_000F, 32'h0000_0100, 32'h8000_0000};
    logic [1:0]  m [4] = '{2'd1, 2'd3, 2'd2, 2'd0};
    int          e [4] = '{12, 4, 8, 0};
    int gc[$]; int gt[$];
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          in_valid = 1'b1; in_data = d[i]; in_mode = m[i]; in_tag = 4'd5;
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 16; j++) begin
          if (out_valid) begin gc.push_back(int'(out_count)); gt.push_back(int'(out_tag)); end
          @(negedge clk);
        end
      end
    join
    n_cmp++; if (gc.size() !== 4) begin n_err++; $display("FAIL modes_n: got %0d expected 4", gc.size()); end
    for (int i = 0; i < 4; i++) begin
      int c = (i < gc.size()) ? gc[i] : -1;
      int t = (i < gt.size()) ? gt[i] : -1;
      n_cmp++; if (c !== e[i]) begin n_err++; $display("FAIL modes_cnt[%0d]: got %0d expected %0d", i, c, e[i]); end
      n_cmp++; if (t !== 5) begin n_err++; $display("FAIL modes_tag[%0d]: got %0d expected 5", i, t); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d [8] = '{32'h8000_0000, 32'h4000_0000, 32'h00F0_0000, 32'h0001_0000,
                           32'h0000_0100, 32'h0000_0010, 32'h0000_0002, 32'h0000_0001};
    int          e [8] = '{0, 1, 8, 15, 23, 27, 30, 31};
    int gc[$]; int gt[$]; int gj[$];
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %0b expected 1", i, in_ready); end
          in_valid = 1'b1; in_data = d[i]; in_mode = CLZ; in_tag = 4'(i);
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 20; j++) begin
          if (out_valid) begin gc.push_back(int'(out_count)); gt.push_back(int'(out_tag)); gj.push_back(j); end
          @(negedge clk);
        end
      end
    join
    n_cmp++; if (gc.size() !== 8) begin n_err++; $display("FAIL b2b_n: got %0d expected 8", gc.size()); end
    for (int i = 0; i < 8; i++) begin
      int c  = (i < gc.size()) ? gc[i] : -1;
      int t  = (i < gt.size()) ? gt[i] : -1;
      int dj = (i < gj.size() && gj.size() > 0) ? gj[i] - gj[0] : -1;
      n_cmp++; if (c !== e[i]) begin n_err++; $display("FAIL b2b_cnt[%0d]: got %0d expected %0d", i, c, e[i]); end
      n_cmp++; if (t !== i) begin n_err++; $display("FAIL b2b_tag[%0d]: got %0d expected %0d", i, t, i); end
      n_cmp++; if (dj !== i) begin n_err++; $display("FAIL b2b_cycle[%0d]: got %0d expected %0d", i, dj, i); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d [4] = '{32'h0000_0001, 32'h0040_0000, 32'hC000_0000, 32'h0000_0080};
    logic [1:0]  m [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
    int          e [4] = '{31, 9, 2, 7};
    int gc[$]; int gt[$];
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = d[i]; in_mode = m[i]; in_tag = 4'(8 + i);
      @(negedge clk);
    end
    in_valid = 1'b1; in_data = d[3]; in_mode = m[3]; in_tag = 4'd11;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %0b expected 0", k, in_ready); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %0b expected 1", k, out_valid); end
      n_cmp++; if (out_count !== 6'd31) begin n_err++; $display("FAIL bp_count[%0d]: got %0d expected 31", k, out_count); end
      n_cmp++; if (out_tag !== 4'd8) begin n_err++; $display("FAIL bp_tag[%0d]: got %0d expected 8", k, out_tag); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c == 1) in_valid = 1'b0;
      if (out_valid) begin gc.push_back(int'(out_count)); gt.push_back(int'(out_tag)); end
      @(negedge clk);
    end
    n_cmp++; if (gc.size() !== 4) begin n_err++; $display("FAIL bp_n: got %0d expected 4", gc.size()); end
    for (int i = 0; i < 4; i++) begin
      int c = (i < gc.size()) ? gc[i] : -1;
      int t = (i < gt.size()) ? gt[i] : -1;
      n_cmp++; if (c !== e[i]) begin n_err++; $display("FAIL bp_cnt[%0d]: got %0d expected %0d", i, c, e[i]); end
      n_cmp++; if (t !== 8 + i) begin n_err++; $display("FAIL bp_tag_drain[%0d]: got %0d expected %0d", i, t, 8 + i); end
    end
  endtask

  task automatic test_flush();
    logic [5:0] c; logic a; logic [3:0] tg; int lat; int seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h0000_0001; in_mode = CLZ; in_tag = 4'(i);
      @(negedge clk);
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h0; in_tag = 4'd15;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL flush_leak: got %0d results expected 0", seen); end
    run_one(32'h0000_0F00, CLZ, 4'd3, c, a, tg, lat);
    n_cmp++; if (c !== 6'd20) begin n_err++; $display("FAIL flush_after_cnt: got %0d expected 20", c); end
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL flush_after_lat: got %0d expected 3", lat); end
    n_cmp++; if (tg !== 4'd3) begin n_err++; $display("FAIL flush_after_tag: got %0d expected 3", tg); end
  endtask

  task automatic test_async_reset();
    int seen = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h0000_0100; in_mode = CLZ; in_tag = 4'd7;
      @(negedge clk);
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre_valid: got %0b expected 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %0b expected 0", out_valid); end
    n_cmp++; if (out_tag !== 4'd0) begin n_err++; $display("FAIL arst_tag: got %0d expected 0", out_tag); end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL arst_in_ready: got %0b expected 1", in_ready); end
    for (int k = 0; k < 6; k++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL arst_partial: got %0d results expected 0", seen); end
  endtask

  task automatic test_sweep();
    int wtab [6] = '{2, 2, 8, 8, 64, 64};
    int ltab [6] = '{1, 1, 3, 1, 6, 2};
    for (int v = 0; v < 12; v++) begin
      int   lat [6];
      int   cnt [6];
      logic al  [6];
      int   tg  [6];
      for (int g = 0; g < 6; g++) begin lat[g] = -1; cnt[g] = -1; al[g] = 1'b0; tg[g] = -1; end
      sw_data  = (v == 0) ? 64'h0 : ((v == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom(), $urandom()});
      sw_mode  = 2'(v % 4);
      sw_tag   = 4'(v);
      sw_valid = 1'b1;
      for (int g = 0; g < 6; g++) begin
        n_cmp++; if (sw_ir[g] !== 1'b1) begin n_err++; $display("FAIL sw_in_ready[%0d]: got %0b expected 1", g, sw_ir[g]); end
      end
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        sw_valid = 1'b0;
        for (int g = 0; g < 6; g++) begin
          if (sw_ov[g] && lat[g] < 0) begin
            lat[g] = i; cnt[g] = int'(sw_cnt[g]); al[g] = sw_all[g]; tg[g] = int'(sw_otag[g]);
          end
        end
      end
      for (int g = 0; g < 6; g++) begin
        int e = ref_cnt(sw_data, wtab[g], sw_mode);
        logic ea = (e == wtab[g]);
        n_cmp++; if (cnt[g] !== e) begin n_err++; $display("FAIL sw_cnt[%0d] v%0d: got %0d expected %0d", g, v, cnt[g], e); end
        n_cmp++; if (al[g] !== ea) begin n_err++; $display("FAIL sw_all[%0d] v%0d: got %0b expected %0b", g, v, al[g], ea); end
        n_cmp++; if (lat[g] !== ltab[g]) begin n_err++; $display("FAIL sw_lat[%0d] v%0d: got %0d expected %0d", g, v, lat[g], ltab[g]); end
        n_cmp++; if (tg[g] !== v) begin n_err++; $display("FAIL sw_tag[%0d] v%0d: got %0d expected %0d", g, v, tg[g], v); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_mode = 2'd0;
    in_tag = 4'd0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_data = 64'h0; sw_mode = 2'd0; sw_tag = 4'd0;
    test_reset();
    test_latency();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
